project_soc_keycode_fifo: RTL and testbench

PROJECT_SOC_KEYCODE_FIFO -- requirements
Module: project_soc_keycode_fifo

---
 rtl/project_soc_keycode_fifo.sv | 126 ++++++++++++
 tb/tb_project_soc_keycode_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/project_soc_keycode_fifo.sv
// rtl/project_soc_keycode_fifo.sv - Avalon-MM keycode FIFO with fall-through output, overflow flag and irq
// Pushes arrive by register writes; the consumer drains via out_valid/out_ready and out_port latches each pop.

module project_soc_keycode_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              irq_en_q, irq_en_d;
  logic [DATA_W-1:0] out_port_q, out_port_d;

  logic wr_en, push_req, ovf_clr, ctrl_wr, flush;
  logic empty, full, pop, push_ok, ovf_set;
  logic [31:0] status, port_ext;
  logic unused_wdata;

  assign unused_wdata = ^writedata;

  always_comb begin
    wr_en    = chipselect && !write_n;
    push_req = wr_en && (address == 2'd0);
    ovf_clr  = wr_en && (address == 2'd1) && writedata[2];
    ctrl_wr  = wr_en && (address == 2'd2);
    flush    = ctrl_wr && writedata[1];
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    // A flush wins over everything else that touches the queue that cycle.
    pop      = !empty && out_ready && !flush;
    push_ok  = push_req && !flush && (!full || pop);
    ovf_set  = push_req && !flush && full && !pop;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;
    out_port_d = out_port_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        out_port_d = mem_q[rd_ptr_q];
      end
      count_d = count_q + {{(CNT_W-1){1'b0}}, push_ok} - {{(CNT_W-1){1'b0}}, pop};
    end
    if (ovf_clr) overflow_d = 1'b0;
    if (ovf_set) overflow_d = 1'b1;
    if (ctrl_wr) irq_en_d = writedata[0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      out_port_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      out_port_q <= out_port_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (reset_n && push_ok) mem_q[wr_ptr_q] <= writedata[DATA_W-1:0];
  end

  always_comb begin
    status = '0;
    port_ext = '0;
    port_ext[DATA_W-1:0] = out_port_q;
    if (!reset_n) begin
      status[0] = 1'b1;
    end else begin
      status[0] = empty;
      status[1] = full;
      status[2] = overflow_q;
      status[8 +: CNT_W] = count_q;
    end
    case (address)
      2'd0:    readdata = port_ext;
      2'd1:    readdata = status;
      2'd2:    readdata = {31'd0, irq_en_q};
      default: readdata = '0;
    endcase
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = reset_n && !empty;
  assign out_port  = out_port_q;
  assign irq       = reset_n && irq_en_q && overflow_q;

endmodule

// File: tb/tb_project_soc_keycode_fifo.sv
// tb/tb_project_soc_keycode_fifo.sv - directed and random checks of the keycode FIFO against a queue model
module tb_project_soc_keycode_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_port;
  logic        irq;

  int tests = 0;
  int fails = 0;

  logic [7:0] mq[$];
  logic [7:0] popped[$];
  logic [7:0] pushed[$];
  logic       m_ovf = 1'b0;
  logic       m_irq_en = 1'b0;
  logic [7:0] m_port = 8'h00;

  project_soc_keycode_fifo dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    logic [31:0] r;
    int n;
    n = mq.size();
    case (a)
      2'd0: r = {24'd0, m_port};
      2'd1: r = (n << 8) | (m_ovf ? 32'h4 : 32'h0) | ((n == DEPTH) ? 32'h2 : 32'h0) | ((n == 0) ? 32'h1 : 32'h0);
      2'd2: r = {31'd0, m_irq_en};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic check_outputs();
    if (!reset_n) begin
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      if (address == 2'd1) check("rst_status", readdata, 32'h1);
    end else begin
      check("valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      if (mq.size() > 0) check("head", {24'd0, out_data}, {24'd0, mq[0]});
      check("irq", {31'd0, irq}, {31'd0, m_ovf & m_irq_en});
      check("readdata", readdata, exp_read(address));
      check("out_port", {24'd0, out_port}, {24'd0, m_port});
    end
  endtask

  task automatic model_step();
    logic wr, fl, was_full, pop, psh, set;
    if (!reset_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_irq_en = 1'b0;
      m_port = 8'h00;
    end else begin
      set = 1'b0;
      wr = chipselect && !write_n;
      fl = wr && address == 2'd2 && writedata[1];
      was_full = (mq.size() == DEPTH);
      pop = (mq.size() > 0) && out_ready && !fl;
      psh = wr && address == 2'd0 && !fl;
      if (wr && address == 2'd2) m_irq_en = writedata[0];
      if (fl) mq.delete();
      else begin
        if (pop) begin
          m_port = mq.pop_front();
          popped.push_back(m_port);
        end
        if (psh) begin
          if (!was_full || pop) mq.push_back(writedata[7:0]);
          else set = 1'b1;
        end
      end
      if (wr && address == 2'd1 && writedata[2]) m_ovf = 1'b0;
      if (set) m_ovf = 1'b1;
    end
  endtask

  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    int n, cyc;
    logic [7:0] v;
    reset_n = 1'b0; address = 2'd1; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; out_ready = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    #1;
    check("r40_status", readdata, 32'h1);
    check("r40_valid", {31'd0, out_valid}, 32'd0);
    check("r40_port", {24'd0, out_port}, 32'd0);
    check("r40_irq", {31'd0, irq}, 32'd0);
    tick();

    // three pushes, then drain in order
    bus_write(0, 32'h1C); bus_write(0, 32'h32); bus_write(0, 32'h23);
    address = 2'd1;
    #1;
    check("r41_status", readdata, 32'h300);
    check("r41_head", {24'd0, out_data}, 32'h1C);
    popped.delete();
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("r41_pop0", {24'd0, popped[0]}, 32'h1C);
    check("r41_pop1", {24'd0, popped[1]}, 32'h32);
    check("r41_pop2", {24'd0, popped[2]}, 32'h23);
    address = 2'd0;
    #1;
    check("r41_port", readdata, 32'h23);
    address = 2'd1;
    #1;
    check("r41_empty", readdata, 32'h1);
    tick();

    // overflow and interrupt
    for (int i = 0; i < 17; i++) bus_write(0, 32'h40 + i);
    address = 2'd1;
    #1;
    check("r42_status", readdata, 32'h1006);
    bus_write(2, 32'h1);
    #1;
    check("r42_irq_on", {31'd0, irq}, 32'd1);
    bus_write(1, 32'h4);
    #1;
    check("r42_irq_off", {31'd0, irq}, 32'd0);
    check("r42_status2", readdata, 32'h1002);

    // push while full with simultaneous pop
    popped.delete();
    out_ready = 1'b1;
    bus_write(0, 32'hAA);
    out_ready = 1'b0;
    address = 2'd1;
    #1;
    check("r43_status", readdata, 32'h1002);
    out_ready = 1'b1;
    repeat (17) tick();
    out_ready = 1'b0;
    check("r43_npop", popped.size(), 32'd17);
    check("r43_aa_pos", {24'd0, popped[16]}, 32'hAA);
    bus_write(2, 32'h0);

    // streaming across pointer wrap
    popped.delete(); pushed.delete();
    n = 0; cyc = 0;
    while (n < 40 && cyc < 400) begin
      out_ready = cyc[0];
      if (mq.size() < 14 && $urandom_range(0, 3) != 0) begin
        v = 8'($urandom);
        pushed.push_back(v);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = {24'd0, v};
        n++;
      end else begin
        chipselect = 1'b0; write_n = 1'b1; address = 2'd1;
      end
      tick();
      cyc++;
    end
    chipselect = 1'b0; write_n = 1'b1;
    check("r44_npush", n, 32'd40);
    out_ready = 1'b1;
    repeat (20) tick();
    out_ready = 1'b0;
    check("r44_npop", popped.size(), pushed.size());
    for (int i = 0; i < pushed.size(); i++) check("r44_order", {24'd0, popped[i]}, {24'd0, pushed[i]});

    // flush with a pending pop, then reset mid-traffic
    for (int i = 0; i < 6; i++) bus_write(0, 32'h60 + i);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    address = 2'd0;
    #1;
    check("r45_port_pre", readdata, 32'h60);
    out_ready = 1'b1;
    bus_write(2, 32'h2);
    out_ready = 1'b0;
    address = 2'd1;
    #1;
    check("r45_flush_status", readdata, 32'h1);
    check("r45_flush_valid", {31'd0, out_valid}, 32'd0);
    address = 2'd0;
    #1;
    check("r45_flush_port", readdata, 32'h60);
    tick();
    for (int i = 0; i < 5; i++) bus_write(0, 32'h70 + i);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    address = 2'd1;
    #1;
    check("r45_rst_status", readdata, 32'h1);
    address = 2'd0;
    #1;
    check("r45_rst_port", readdata, 32'h0);
    tick();

    // random traffic
    repeat (600) begin
      reset_n    = ($urandom_range(0, 149) != 0);
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) == 0);
      address    = 2'($urandom);
      if ($urandom_range(0, 1) == 0) address = 2'd0;
      writedata  = $urandom;
      if (address == 2'd2 && $urandom_range(0, 3) != 0) writedata[1] = 1'b0;
      out_ready  = ($urandom_range(0, 2) == 0);
      tick();
    end
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
